// File: rtl/testblock_axil_arbiter.sv
// testblock_axil_arbiter
// Two-requester round-robin front end for the Testblock S00_AXI register port.
// Each requester issues single-word read/write commands on a level req/ack
// handshake; one AXI4-Lite transaction is sequenced at a time on the master port.
module testblock_axil_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_BASE_ADDR        = 0
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [1:0]                      req,
  input  logic [1:0]                      we,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr0,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr1,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata0,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata1,
  output logic [1:0]                      ack,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                      resp,
  output logic                            busy,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [AW-1:0] BASE       = AW'(C_BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDATA,
    S_DONE
  } state_t;

  // Word-align the requester address, then offset into the register window;
  // the sum wraps within the address width.
  function automatic logic [AW-1:0] form_addr(input logic [AW-1:0] a);
    return (a & ALIGN_MASK) + BASE;
  endfunction

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [1:0]      ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic            awvalid_q, awvalid_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;

  logic            sel;
  logic            aw_done;
  logic            w_done;

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that it leaves the block straight from a flop.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ack_d        = 2'b00;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    sel          = 1'b0;
    aw_done      = 1'b0;
    w_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester not served last wins; otherwise the lone one.
          if (req == 2'b11) sel = ~last_grant_q;
          else              sel = req[1];
          grant_d      = sel;
          last_grant_d = sel;
          if (we[sel]) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = form_addr(sel ? addr1 : addr0);
            wdata_d   = sel ? wdata1 : wdata0;
          end else begin
            state_d   = S_READ;
            arvalid_d = 1'b1;
            araddr_d  = form_addr(sel ? addr1 : addr0);
          end
        end
      end

      S_WRITE: begin
        // A channel is done once its valid has already dropped or its
        // handshake happens this cycle; the two channels finish independently.
        aw_done = !awvalid_q || m_axi_awready;
        w_done  = !wvalid_q  || m_axi_wready;
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q  && m_axi_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end

      S_WRESP: begin
        if (m_axi_bvalid) begin
          bready_d        = 1'b0;
          resp_d          = m_axi_bresp;
          ack_d[grant_q]  = 1'b1;
          state_d         = S_DONE;
        end
      end

      S_READ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (m_axi_rvalid) begin
          rready_d        = 1'b0;
          rdata_d         = m_axi_rdata;
          resp_d          = m_axi_rresp;
          ack_d[grant_q]  = 1'b1;
          state_d         = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
      busy_q       <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      busy_q       <= busy_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
    end
  end

  assign ack           = ack_q;
  assign rdata         = rdata_q;
  assign resp          = resp_q;
  assign busy          = busy_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
